xix_stack_sequencer: RTL and testbench
======================================

// Module: xix_stack_sequencer
// PURPOSE
//  Clocked sequencer for index-prefixed 11xxxxxx ops: POP/PUSH/EX (SP),Ixx/JP (Ixx)/LD SP,Ixx.
//  Generalised to NUM_IDX index registers of REG_BYTES bytes each.
//  Owns its phase/byte counter (no external XPT); stalls on memory handshake.
//  Pulses done at end of op, which drives next opcode fetch (Set_CM1/Ophd equivalent).
// PARAMETERS
//  NUM_IDX    2  index registers selectable (IX, IY, ...); IDX_W = max(1,$clog2(NUM_IDX))
//  REG_BYTES  2  bytes per index register; BYTE_W = max(1,$clog2(REG_BYTES))
// PORTS
//  CLK        in   1                  clock, rising edge
//  notRESET   in   1                  asynchronous, active-low reset
//  start      in   1                  op valid; accepted only when busy=0
//  opcode     in   8                  second byte after prefix; sampled with start
//  idx_sel    in   IDX_W              index register; latched on accepted start
//  mem_rdy    in   1                  memory cycle completes when mem_req & mem_rdy
//  busy       out  1                  op in progress
//  reg_idx    out  IDX_W              latched idx_sel, drives external register mux
//  mem_req    out  1                  memory cycle request, address = SP + ad_ofs
//  mem_we     out  1                  1 = write cycle, valid with mem_req
//  ad_ofs     out  BYTE_W             address offset from SP (EX only, else 0)
//  dt_sel     out  BYTE_W             register byte driven on write data bus
//  dt_from_tmp out 1                  EX: register byte loaded from temp latch, not bus
//  tmp_we     out  1                  EX: latch read byte into temp
//  reg_we     out  NUM_IDX*REG_BYTES  byte write strobe [idx*REG_BYTES+byte]
//  sp_inc     out  1                  SP <= SP+1 pulse
//  sp_dec     out  1                  SP <= SP-1 pulse
//  pc_we      out  1                  PC <= reg[reg_idx]
//  sp_we      out  1                  SP <= reg[reg_idx]
//  done       out  1                  one-cycle end-of-op pulse
//  illegal    out  1                  one-cycle pulse, unsupported opcode
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, byte counter 0, reg_idx 0. Mid-op reset abandons the op
//   with no completion strobe.
//  States: IDLE, POP, PUSH_DEC, PUSH_WR, EX_RD, EX_WR, FIN.
//  IDLE + start: E1->POP; E5->PUSH_DEC; E3->EX_RD; E9/F9->FIN. Other opcodes: illegal=1 and
//   done=1 for the next cycle, then IDLE. start while busy is ignored.
//  POP: byte k = 0..REG_BYTES-1, low byte first. mem_req=1, mem_we=0. On handshake:
//   reg_we[k]=1 and sp_inc=1. After the last byte -> FIN.
//  PUSH: k from REG_BYTES-1 down to 0. PUSH_DEC: sp_dec for one cycle. PUSH_WR: mem_req=1,
//   mem_we=1, dt_sel=k until handshake. Repeat, then FIN.
//  EX: per byte k (ad_ofs=k). EX_RD: read; tmp_we on handshake. EX_WR: write with dt_sel=k;
//   on handshake reg_we[k]=1 with dt_from_tmp=1. SP is unchanged. After the last byte -> FIN.
//  FIN: done=1 for one cycle -> IDLE. For E9, pc_we=1 in the FIN cycle; for F9, sp_we=1.
//  Strobes (reg_we, sp_inc, tmp_we) are one-cycle and fire only in the handshake cycle.
//   mem_req is held while mem_rdy=0, with outputs stable.
//  Latency with mem_rdy=1: JP/LD 1 cycle to done. POP REG_BYTES+1. PUSH 2*REG_BYTES+1.
//   EX 2*REG_BYTES+1.
//  Byte counter is BYTE_W wide. Terminal test is k==REG_BYTES-1 (POP/EX) or k==0 (PUSH),
//   so the counter never wraps through the unused codes.
//  busy=1 from the cycle after accepted start through the done cycle.
// CONFIGURATION
//  XIX_EXSP_EN defined: E3 sequenced as above.
//  XIX_EXSP_EN undefined: E3 treated as illegal; EX states, tmp_we and dt_from_tmp tied 0.
// STRUCTURE
//  xix_seq_pkg: opcode localparams (OP_POP=8'hE1, OP_EX=8'hE3, OP_PUSH=8'hE5, OP_JP=8'hE9,
//   OP_LDSP=8'hF9), state enum, width helper functions.
//  Sub-module xix_seq_opdecode: combinational opcode -> first-state/illegal mapping.
// TESTING
//  POP, idx=1, REG_BYTES=2, mem_rdy=1 -> reg_we bit2 then bit3 plus 2x sp_inc; done at cycle 3.
//  PUSH, idx=0, mem_rdy low 2 cycles on first write -> sp_dec, dt_sel=1 held 3 cycles,
//   sp_dec, dt_sel=0; done once.
//  EX, idx=0 -> tmp_we, then reg_we[0] with dt_from_tmp, then ad_ofs=1 sequence;
//   no sp_inc/sp_dec. Without XIX_EXSP_EN -> illegal+done at cycle 1.
//  E9 -> pc_we=done=1 at cycle 1. F9 -> sp_we=1 at cycle 1. Opcode 8'h21 -> illegal=done=1,
//   no other strobe.
//  start pulsed during a POP -> ignored; notRESET low mid-PUSH -> all outputs 0 asynchronously,
//   no done.
//  NUM_IDX=4, REG_BYTES=4 POP idx=3 -> reg_we bits 12..15 in order; done at cycle 5.

Source files
------------

// File: rtl/xix_stack_sequencer_pkg.sv
// Shared definitions for the index-prefixed stack sequencer: opcodes, FSM state codes,
// completion kinds and width helpers.
package xix_seq_pkg;

  localparam logic [7:0] OP_POP  = 8'hE1;
  localparam logic [7:0] OP_EX   = 8'hE3;
  localparam logic [7:0] OP_PUSH = 8'hE5;
  localparam logic [7:0] OP_JP   = 8'hE9;
  localparam logic [7:0] OP_LDSP = 8'hF9;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_POP      = 3'd1;
  localparam state_t ST_PUSH_DEC = 3'd2;
  localparam state_t ST_PUSH_WR  = 3'd3;
  localparam state_t ST_EX_RD    = 3'd4;
  localparam state_t ST_EX_WR    = 3'd5;
  localparam state_t ST_FIN      = 3'd6;

  // What the FIN cycle strobes besides done.
  typedef enum logic [1:0] {FIN_NONE, FIN_JP, FIN_LDSP, FIN_ILLEGAL} fin_e;

  function automatic int clog2_min1(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xix_stack_sequencer_if.sv
// Host/memory side bundle of the stack sequencer. master = host + memory, slave = sequencer.
interface xix_stack_sequencer_if
  import xix_seq_pkg::*;
#(
  parameter int NUM_IDX   = 2,
  parameter int REG_BYTES = 2
) ();

  localparam int IDX_W  = clog2_min1(NUM_IDX);
  localparam int BYTE_W = clog2_min1(REG_BYTES);
  localparam int NREG   = NUM_IDX * REG_BYTES;

  logic              start;
  logic [7:0]        opcode;
  logic [IDX_W-1:0]  idx_sel;
  logic              mem_rdy;
  logic              busy;
  logic [IDX_W-1:0]  reg_idx;
  logic              mem_req;
  logic              mem_we;
  logic [BYTE_W-1:0] ad_ofs;
  logic [BYTE_W-1:0] dt_sel;
  logic              dt_from_tmp;
  logic              tmp_we;
  logic [NREG-1:0]   reg_we;
  logic              sp_inc;
  logic              sp_dec;
  logic              pc_we;
  logic              sp_we;
  logic              done;
  logic              illegal;

  modport master (
    output start, opcode, idx_sel, mem_rdy,
    input  busy, reg_idx, mem_req, mem_we, ad_ofs, dt_sel, dt_from_tmp, tmp_we,
           reg_we, sp_inc, sp_dec, pc_we, sp_we, done, illegal
  );

  modport slave (
    input  start, opcode, idx_sel, mem_rdy,
    output busy, reg_idx, mem_req, mem_we, ad_ofs, dt_sel, dt_from_tmp, tmp_we,
           reg_we, sp_inc, sp_dec, pc_we, sp_we, done, illegal
  );

endinterface

// File: rtl/xix_stack_sequencer_opdecode.sv
// Maps the post-prefix opcode to the first sequencer state and the FIN-cycle strobe kind.
// EX (SP),Ixx is decoded only when XIX_EXSP_EN is defined.
module xix_seq_opdecode
  import xix_seq_pkg::*;
(
  input  logic [7:0] opcode_i,
  output state_t     first_state_o,
  output fin_e       fin_kind_o
);

  // NOTE: both outputs get a default before the case so no path can infer a latch.
  always_comb begin
    first_state_o = ST_FIN;
    fin_kind_o    = FIN_ILLEGAL;
    case (opcode_i)
      OP_POP:  begin first_state_o = ST_POP;      fin_kind_o = FIN_NONE; end
      OP_PUSH: begin first_state_o = ST_PUSH_DEC; fin_kind_o = FIN_NONE; end
`ifdef XIX_EXSP_EN
      OP_EX:   begin first_state_o = ST_EX_RD;    fin_kind_o = FIN_NONE; end
`endif
      OP_JP:   begin first_state_o = ST_FIN;      fin_kind_o = FIN_JP;   end
      OP_LDSP: begin first_state_o = ST_FIN;      fin_kind_o = FIN_LDSP; end
      default: ;
    endcase
  end

endmodule

// File: rtl/xix_stack_sequencer.sv
// Sequencer for POP/PUSH/EX (SP),Ixx, JP (Ixx) and LD SP,Ixx with its own byte counter.
// Define XIX_EXSP_EN to enable EX (SP),Ixx; otherwise E3 is reported illegal.
module xix_stack_sequencer
  import xix_seq_pkg::*;
#(
  parameter int NUM_IDX   = 2,
  parameter int REG_BYTES = 2
) (
  input logic CLK,
  input logic notRESET,
  xix_stack_sequencer_if.slave bus
);

  localparam int IDX_W  = clog2_min1(NUM_IDX);
  localparam int BYTE_W = clog2_min1(REG_BYTES);
  localparam int NREG   = NUM_IDX * REG_BYTES;
  localparam logic [BYTE_W-1:0] K_LAST = BYTE_W'(REG_BYTES - 1);

  state_t            state_q, state_d;
  logic [BYTE_W-1:0] k_q, k_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  fin_e              fin_q, fin_d;

  state_t dec_state;
  fin_e   dec_fin;
  logic   mem_req, mem_we, hs;

  xix_seq_opdecode u_opdecode (
    .opcode_i      (bus.opcode),
    .first_state_o (dec_state),
    .fin_kind_o    (dec_fin)
  );

  assign mem_req = (state_q == ST_POP) || (state_q == ST_PUSH_WR) ||
                   (state_q == ST_EX_RD) || (state_q == ST_EX_WR);
  assign mem_we  = (state_q == ST_PUSH_WR) || (state_q == ST_EX_WR);
  assign hs      = mem_req && bus.mem_rdy;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    idx_d   = idx_q;
    fin_d   = fin_q;
    case (state_q)
      ST_IDLE: if (bus.start) begin
        state_d = dec_state;
        fin_d   = dec_fin;
        idx_d   = bus.idx_sel;
        k_d     = (dec_state == ST_PUSH_DEC) ? K_LAST : '0;
      end
      ST_POP: if (hs) begin
        if (k_q == K_LAST) state_d = ST_FIN;
        else               k_d = k_q + 1'b1;
      end
      ST_PUSH_DEC: state_d = ST_PUSH_WR;
      // PUSH walks high byte down so the low byte lands at the final SP.
      ST_PUSH_WR: if (hs) begin
        if (k_q == '0) state_d = ST_FIN;
        else begin
          k_d     = k_q - 1'b1;
          state_d = ST_PUSH_DEC;
        end
      end
`ifdef XIX_EXSP_EN
      ST_EX_RD: if (hs) state_d = ST_EX_WR;
      ST_EX_WR: if (hs) begin
        if (k_q == K_LAST) state_d = ST_FIN;
        else begin
          k_d     = k_q + 1'b1;
          state_d = ST_EX_RD;
        end
      end
`endif
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK or negedge notRESET) begin
    if (!notRESET) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      idx_q   <= '0;
      fin_q   <= FIN_NONE;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      idx_q   <= idx_d;
      fin_q   <= fin_d;
    end
  end

  // Byte strobe lands on bit reg_idx*REG_BYTES + k, only in the completing cycle.
  always_comb begin
    bus.reg_we = '0;
    for (int i = 0; i < NREG; i++) begin
      bus.reg_we[i] = hs && ((state_q == ST_POP) || (state_q == ST_EX_WR)) &&
                      (i == int'(idx_q) * REG_BYTES + int'(k_q));
    end
  end

  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.reg_idx = idx_q;
  assign bus.mem_req = mem_req;
  assign bus.mem_we  = mem_we;
  assign bus.ad_ofs  = ((state_q == ST_EX_RD) || (state_q == ST_EX_WR)) ? k_q : '0;
  assign bus.dt_sel  = mem_we ? k_q : '0;
  assign bus.sp_inc  = hs && (state_q == ST_POP);
  assign bus.sp_dec  = (state_q == ST_PUSH_DEC);
  assign bus.done    = (state_q == ST_FIN);
  assign bus.pc_we   = (state_q == ST_FIN) && (fin_q == FIN_JP);
  assign bus.sp_we   = (state_q == ST_FIN) && (fin_q == FIN_LDSP);
  assign bus.illegal = (state_q == ST_FIN) && (fin_q == FIN_ILLEGAL);

`ifdef XIX_EXSP_EN
  assign bus.tmp_we      = hs && (state_q == ST_EX_RD);
  assign bus.dt_from_tmp = (state_q == ST_EX_WR);
`else
  assign bus.tmp_we      = 1'b0;
  assign bus.dt_from_tmp = 1'b0;
`endif

endmodule

// File: tb/tb_xix_stack_sequencer.sv
// Directed bench for xix_stack_sequencer: a 2x2-byte instance for every op plus a 4x4-byte POP.
module tb_xix_stack_sequencer;
  import xix_seq_pkg::*;

  logic CLK = 1'b0;
  logic notRESET = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0, inc_cnt = 0, dec_cnt = 0;

  always #5 CLK = ~CLK;

  xix_stack_sequencer_if #(.NUM_IDX(2), .REG_BYTES(2)) bus ();
  xix_stack_sequencer_if #(.NUM_IDX(4), .REG_BYTES(4)) bus4 ();

  xix_stack_sequencer #(.NUM_IDX(2), .REG_BYTES(2)) dut (
    .CLK(CLK), .notRESET(notRESET), .bus(bus));
  xix_stack_sequencer #(.NUM_IDX(4), .REG_BYTES(4)) dut4 (
    .CLK(CLK), .notRESET(notRESET), .bus(bus4));

  always @(negedge CLK) begin
    done_cnt <= done_cnt + int'(bus.done);
    inc_cnt  <= inc_cnt + int'(bus.sp_inc);
    dec_cnt  <= dec_cnt + int'(bus.sp_dec);
  end

  function automatic logic [63:0] outs2();
    return 64'({bus.busy, bus.mem_req, bus.mem_we, bus.ad_ofs, bus.dt_sel, bus.dt_from_tmp,
                bus.tmp_we, bus.reg_we, bus.sp_inc, bus.sp_dec, bus.pc_we, bus.sp_we,
                bus.done, bus.illegal, bus.reg_idx});
  endfunction

  function automatic logic [63:0] outs4();
    return 64'({bus4.busy, bus4.mem_req, bus4.mem_we, bus4.ad_ofs, bus4.dt_sel,
                bus4.dt_from_tmp, bus4.tmp_we, bus4.reg_we, bus4.sp_inc, bus4.sp_dec,
                bus4.pc_we, bus4.sp_we, bus4.done, bus4.illegal, bus4.reg_idx});
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Presents one op for a single edge; returns during cycle 1 of the op.
  task automatic issue(input logic [7:0] op, input logic idx);
    bus.opcode  = op;
    bus.idx_sel = idx;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 0; bus.opcode = 0; bus.idx_sel = 0; bus.mem_rdy = 0;
    bus4.start = 0; bus4.opcode = 0; bus4.idx_sel = 0; bus4.mem_rdy = 0;
    notRESET = 1'b0;
    #3;
    checks++;
    if (outs2() !== 64'd0) begin
      failures++; $display("FAIL reset_outs2 got=%0h exp=0", outs2());
    end
    checks++;
    if (outs4() !== 64'd0) begin
      failures++; $display("FAIL reset_outs4 got=%0h exp=0", outs4());
    end
    tick();
    notRESET = 1'b1;
    tick();
  endtask

  task automatic test_pop();
    bus.mem_rdy = 1'b1;
    issue(OP_POP, 1'b1);
    checks++;
    if ({bus.busy, bus.reg_idx, bus.mem_req, bus.mem_we, bus.sp_inc, bus.reg_we, bus.done}
        !== {4'b1110, 1'b1, 4'b0100, 1'b0}) begin
      failures++; $display("FAIL pop_c1 got=%0h exp=%0h",
        {bus.busy, bus.reg_idx, bus.mem_req, bus.mem_we, bus.sp_inc, bus.reg_we, bus.done},
        {4'b1110, 1'b1, 4'b0100, 1'b0});
    end
    tick();
    checks++;
    if ({bus.mem_req, bus.sp_inc, bus.reg_we, bus.done} !== {2'b11, 4'b1000, 1'b0}) begin
      failures++; $display("FAIL pop_c2 got=%0h exp=%0h",
        {bus.mem_req, bus.sp_inc, bus.reg_we, bus.done}, {2'b11, 4'b1000, 1'b0});
    end
    tick();
    checks++;
    if ({bus.done, bus.busy, bus.mem_req, bus.sp_inc, bus.reg_we, bus.pc_we, bus.illegal}
        !== {4'b1100, 4'b0000, 2'b00}) begin
      failures++; $display("FAIL pop_c3_done got=%0h exp=%0h",
        {bus.done, bus.busy, bus.mem_req, bus.sp_inc, bus.reg_we, bus.pc_we, bus.illegal},
        {4'b1100, 4'b0000, 2'b00});
    end
    tick();
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      failures++; $display("FAIL pop_c4_idle got=%0b exp=00", {bus.busy, bus.done});
    end
  endtask

  task automatic test_push_stall();
    int d0;
    d0 = done_cnt;
    bus.mem_rdy = 1'b0;
    issue(OP_PUSH, 1'b0);
    checks++;
    if ({bus.sp_dec, bus.mem_req, bus.sp_inc} !== 3'b100) begin
      failures++; $display("FAIL push_c1_dec got=%0b exp=100", {bus.sp_dec, bus.mem_req, bus.sp_inc});
    end
    for (int c = 2; c <= 4; c++) begin
      tick();
      if (c == 4) bus.mem_rdy = 1'b1;
      checks++;
      if ({bus.mem_req, bus.mem_we, bus.dt_sel, bus.sp_dec, bus.reg_we, bus.done}
          !== {4'b1110, 4'b0000, 1'b0}) begin
        failures++; $display("FAIL push_c%0d_wr1 got=%0h exp=%0h", c,
          {bus.mem_req, bus.mem_we, bus.dt_sel, bus.sp_dec, bus.reg_we, bus.done},
          {4'b1110, 4'b0000, 1'b0});
      end
    end
    tick();
    checks++;
    if ({bus.sp_dec, bus.mem_req} !== 2'b10) begin
      failures++; $display("FAIL push_c5_dec got=%0b exp=10", {bus.sp_dec, bus.mem_req});
    end
    tick();
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.dt_sel, bus.sp_dec} !== 4'b1100) begin
      failures++; $display("FAIL push_c6_wr0 got=%0b exp=1100",
        {bus.mem_req, bus.mem_we, bus.dt_sel, bus.sp_dec});
    end
    tick();
    checks++;
    if ({bus.done, bus.mem_req} !== 2'b10) begin
      failures++; $display("FAIL push_c7_done got=%0b exp=10", {bus.done, bus.mem_req});
    end
    tick(); tick();
    checks++;
    if (done_cnt - d0 !== 1) begin
      failures++; $display("FAIL push_done_count got=%0d exp=1", done_cnt - d0);
    end
  endtask

  task automatic test_ex();
    int i0, e0;
    i0 = inc_cnt; e0 = dec_cnt;
    bus.mem_rdy = 1'b1;
    issue(OP_EX, 1'b0);
`ifdef XIX_EXSP_EN
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.ad_ofs, bus.tmp_we, bus.reg_we, bus.dt_from_tmp}
        !== {4'b1001, 4'b0000, 1'b0}) begin
      failures++; $display("FAIL ex_c1_rd0 got=%0h exp=%0h",
        {bus.mem_req, bus.mem_we, bus.ad_ofs, bus.tmp_we, bus.reg_we, bus.dt_from_tmp},
        {4'b1001, 4'b0000, 1'b0});
    end
    tick();
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.ad_ofs, bus.dt_sel, bus.tmp_we, bus.reg_we, bus.dt_from_tmp}
        !== {5'b11000, 4'b0001, 1'b1}) begin
      failures++; $display("FAIL ex_c2_wr0 got=%0h exp=%0h",
        {bus.mem_req, bus.mem_we, bus.ad_ofs, bus.dt_sel, bus.tmp_we, bus.reg_we, bus.dt_from_tmp},
        {5'b11000, 4'b0001, 1'b1});
    end
    tick();
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.ad_ofs, bus.tmp_we, bus.reg_we}
        !== {4'b1011, 4'b0000}) begin
      failures++; $display("FAIL ex_c3_rd1 got=%0h exp=%0h",
        {bus.mem_req, bus.mem_we, bus.ad_ofs, bus.tmp_we, bus.reg_we}, {4'b1011, 4'b0000});
    end
    tick();
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.ad_ofs, bus.dt_sel, bus.tmp_we, bus.reg_we, bus.dt_from_tmp}
        !== {5'b11110, 4'b0010, 1'b1}) begin
      failures++; $display("FAIL ex_c4_wr1 got=%0h exp=%0h",
        {bus.mem_req, bus.mem_we, bus.ad_ofs, bus.dt_sel, bus.tmp_we, bus.reg_we, bus.dt_from_tmp},
        {5'b11110, 4'b0010, 1'b1});
    end
    tick();
    checks++;
    if ({bus.done, bus.illegal, bus.mem_req} !== 3'b100) begin
      failures++; $display("FAIL ex_c5_done got=%0b exp=100", {bus.done, bus.illegal, bus.mem_req});
    end
`else
    checks++;
    if ({bus.illegal, bus.done, bus.tmp_we, bus.mem_req, bus.reg_we} !== {4'b1100, 4'b0000}) begin
      failures++; $display("FAIL ex_disabled_illegal got=%0h exp=%0h",
        {bus.illegal, bus.done, bus.tmp_we, bus.mem_req, bus.reg_we}, {4'b1100, 4'b0000});
    end
`endif
    tick(); tick();
    checks++;
    if ({bus.busy, 32'(inc_cnt - i0), 32'(dec_cnt - e0)} !== 65'd0) begin
      failures++; $display("FAIL ex_sp_untouched busy=%0b inc=%0d dec=%0d exp=0/0/0",
        bus.busy, inc_cnt - i0, dec_cnt - e0);
    end
  endtask

  task automatic test_jp_ld_illegal();
    issue(OP_JP, 1'b1);
    checks++;
    if ({bus.done, bus.pc_we, bus.sp_we, bus.illegal, bus.busy, bus.reg_idx} !== 6'b110011) begin
      failures++; $display("FAIL jp_c1 got=%0b exp=110011",
        {bus.done, bus.pc_we, bus.sp_we, bus.illegal, bus.busy, bus.reg_idx});
    end
    tick();
    issue(OP_LDSP, 1'b0);
    checks++;
    if ({bus.done, bus.pc_we, bus.sp_we, bus.illegal, bus.busy, bus.reg_idx} !== 6'b101010) begin
      failures++; $display("FAIL ldsp_c1 got=%0b exp=101010",
        {bus.done, bus.pc_we, bus.sp_we, bus.illegal, bus.busy, bus.reg_idx});
    end
    tick();
    issue(8'h21, 1'b0);
    checks++;
    if ({bus.illegal, bus.done, bus.pc_we, bus.sp_we, bus.mem_req, bus.sp_inc, bus.sp_dec,
         bus.tmp_we, bus.reg_we} !== {8'b11000000, 4'b0000}) begin
      failures++; $display("FAIL illegal_21 got=%0h exp=%0h",
        {bus.illegal, bus.done, bus.pc_we, bus.sp_we, bus.mem_req, bus.sp_inc, bus.sp_dec,
         bus.tmp_we, bus.reg_we}, {8'b11000000, 4'b0000});
    end
    tick();
    checks++;
    if ({bus.busy, bus.illegal, bus.done} !== 3'b000) begin
      failures++; $display("FAIL illegal_after got=%0b exp=000", {bus.busy, bus.illegal, bus.done});
    end
  endtask

  task automatic test_start_ignored();
    int i0;
    i0 = inc_cnt;
    bus.mem_rdy = 1'b0;
    issue(OP_POP, 1'b1);
    bus.opcode = OP_JP; bus.idx_sel = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.reg_idx, bus.pc_we, bus.done} !== 5'b10100) begin
      failures++; $display("FAIL busy_start_ignored got=%0b exp=10100",
        {bus.mem_req, bus.mem_we, bus.reg_idx, bus.pc_we, bus.done});
    end
    bus.mem_rdy = 1'b1;
    tick(); tick();
    checks++;
    if ({bus.done, bus.pc_we, bus.illegal, bus.reg_idx} !== 4'b1001) begin
      failures++; $display("FAIL busy_start_fin got=%0b exp=1001",
        {bus.done, bus.pc_we, bus.illegal, bus.reg_idx});
    end
    tick(); tick();
    checks++;
    if ({bus.busy, 32'(inc_cnt - i0)} !== {1'b0, 32'd2}) begin
      failures++; $display("FAIL busy_start_tail busy=%0b inc=%0d exp=0/2", bus.busy, inc_cnt - i0);
    end
  endtask

  task automatic test_reset_mid_push();
    int d0;
    d0 = done_cnt;
    bus.mem_rdy = 1'b0;
    issue(OP_PUSH, 1'b1);
    tick();
    #2 notRESET = 1'b0;
    #1;
    checks++;
    if (outs2() !== 64'd0) begin
      failures++; $display("FAIL reset_mid_push got=%0h exp=0", outs2());
    end
    tick(); tick();
    notRESET = 1'b1;
    tick(); tick();
    checks++;
    if ({bus.busy, 32'(done_cnt - d0)} !== 33'd0) begin
      failures++; $display("FAIL reset_mid_push_nodone busy=%0b done=%0d exp=0/0",
        bus.busy, done_cnt - d0);
    end
  endtask

  task automatic test_wide_pop();
    logic [15:0] exp_we;
    bus4.mem_rdy = 1'b1; bus4.opcode = OP_POP; bus4.idx_sel = 2'd3; bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    exp_we = 16'h1000;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({bus4.reg_we, bus4.sp_inc, bus4.done} !== {exp_we, 2'b10}) begin
        failures++; $display("FAIL wide_pop_byte%0d got=%0h exp=%0h", k,
          {bus4.reg_we, bus4.sp_inc, bus4.done}, {exp_we, 2'b10});
      end
      exp_we = exp_we << 1;
      tick();
    end
    checks++;
    if ({bus4.done, bus4.reg_we, bus4.reg_idx} !== {1'b1, 16'h0000, 2'd3}) begin
      failures++; $display("FAIL wide_pop_done got=%0h exp=%0h",
        {bus4.done, bus4.reg_we, bus4.reg_idx}, {1'b1, 16'h0000, 2'd3});
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_pop();
    test_push_stall();
    test_ex();
    test_jp_ld_illegal();
    test_start_ignored();
    test_reset_mid_push();
    test_wide_pop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
